// File: rtl/cmplxdiv_pkg.sv
// rtl/cmplxdiv_pkg.sv - shared widths, saturation limits and FSM encoding for cmplxdiv
package cmplxdiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_DRE,
        ST_DIM,
        ST_DONE
    } state_t;

    function automatic int nw_f(input int dbw);
        return 3 * dbw + 1;
    endfunction

    function automatic int denw_f(input int dbw);
        return 2 * dbw;
    endfunction

    function automatic int sat_pos_f(input int dbw);
        return (2 ** (dbw - 1)) - 1;
    endfunction

    function automatic int sat_neg_mag_f(input int dbw);
        return 2 ** (dbw - 1);
    endfunction

endpackage

// File: rtl/cmplxdiv_udiv.sv
// rtl/cmplxdiv_udiv.sv - iterative restoring unsigned divider, one quotient bit per cycle
module cmplxdiv_udiv #(
    parameter int NW   = 10,
    parameter int DENW = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [NW-1:0]   dividend,
    input  logic [DENW-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [NW-1:0]   quotient
);
    localparam int CW = $clog2(NW);

    logic [DENW-1:0] rem;
    logic [DENW-1:0] d;
    logic [NW-1:0]   q;
    logic [CW-1:0]   cnt;

    logic [NW-1:0]   q_src;
    logic [DENW-1:0] rem_src;
    logic [DENW-1:0] d_src;
    logic [DENW:0]   shifted;
    logic            fits;
    logic [DENW-1:0] rem_next;
    logic [NW-1:0]   q_next;

    // The start cycle already performs the first step, so NW steps span NW edges.
    assign q_src    = start ? dividend : q;
    assign rem_src  = start ? '0 : rem;
    assign d_src    = start ? divisor : d;
    assign shifted  = {rem_src, q_src[NW-1]};
    assign fits     = shifted >= {1'b0, d_src};
    assign rem_next = fits ? DENW'(shifted - {1'b0, d_src}) : shifted[DENW-1:0];
    assign q_next   = {q_src[NW-2:0], fits};
    assign quotient = q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem  <= '0;
            d    <= '0;
            q    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            rem  <= rem_next;
            q    <= q_next;
            d    <= divisor;
            cnt  <= CW'(NW - 2);
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            rem <= rem_next;
            q   <= q_next;
            if (cnt == '0) begin
                busy <= 1'b0;
                done <= 1'b1;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/cmplxdiv.sv
// rtl/cmplxdiv.sv - sequential complex divider: (a+bj)/(c+dj) with truncation and saturation
module cmplxdiv
    import cmplxdiv_pkg::*;
#(
    parameter int DBW = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*DBW-1:0]   dvd,
    input  logic [2*DBW-1:0]   dvs,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*DBW-1:0]   quot,
    output logic               sat,
    output logic               dz
);
    localparam int NW   = nw_f(DBW);
    localparam int DENW = denw_f(DBW);
    localparam int CW   = $clog2(NW + 1);
    localparam logic [NW-1:0] POS_LIM = NW'(sat_pos_f(DBW));
    localparam logic [NW-1:0] NEG_LIM = NW'(sat_neg_mag_f(DBW));

    state_t          state;
    logic [4*DBW-1:0] dvd_r;
    logic [2*DBW-1:0] dvs_r;
    logic [NW-1:0]   mag_re;
    logic [NW-1:0]   mag_im;
    logic            neg_re;
    logic            neg_im;
    logic [DENW-1:0] den_r;
    logic [CW-1:0]   cnt;
    logic [DBW-1:0]  q_re;
    logic            sat_re;

    logic signed [NW-1:0] a_x, b_x, c_x, d_x, nre_c, nim_c;
    logic [NW-1:0]   mag_re_c, mag_im_c;
    logic [DENW-1:0] den_c;
    logic            div_start, div_busy, div_done;
    logic [NW-1:0]   div_dividend, div_q;
    logic [DBW:0]    re_res, im_res;
    logic            dz_c;

    // Returns {sat, value}; a zero magnitude is 0 whatever its sign.
    function automatic logic [DBW:0] sat_fn(input logic [NW-1:0] mag, input logic neg);
        logic [NW-1:0] neg_mag;
        logic [NW-1:0] lim_neg;
        neg_mag = -mag;
        lim_neg = -NEG_LIM;
        if (mag == '0)
            return '0;
        else if (!neg)
            return (mag > POS_LIM) ? {1'b1, POS_LIM[DBW-1:0]} : {1'b0, mag[DBW-1:0]};
        else
            return (mag > NEG_LIM) ? {1'b1, lim_neg[DBW-1:0]} : {1'b0, neg_mag[DBW-1:0]};
    endfunction

    assign a_x   = NW'($signed(dvd_r[4*DBW-1:2*DBW]));
    assign b_x   = NW'($signed(dvd_r[2*DBW-1:0]));
    assign c_x   = NW'($signed(dvs_r[DBW-1:0]));
    assign d_x   = NW'($signed(dvs_r[2*DBW-1:DBW]));
    assign nre_c = a_x * c_x + b_x * d_x;
    assign nim_c = b_x * c_x - a_x * d_x;
    assign den_c = DENW'(c_x * c_x + d_x * d_x);
    assign mag_re_c = nre_c[NW-1] ? $unsigned(-nre_c) : $unsigned(nre_c);
    assign mag_im_c = nim_c[NW-1] ? $unsigned(-nim_c) : $unsigned(nim_c);

    assign div_start = !div_busy &&
                       (((state == ST_DRE) && (cnt == CW'(NW - 1))) ||
                        ((state == ST_DIM) && (cnt == CW'(NW))));
    assign div_dividend = (state == ST_DIM) ? mag_im : mag_re;
    assign re_res = sat_fn(div_q, neg_re);
    assign im_res = sat_fn(div_q, neg_im);
    assign dz_c   = (den_r == '0);

    cmplxdiv_udiv #(
        .NW   (NW),
        .DENW (DENW)
    ) u_udiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (den_r),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            dvd_r     <= '0;
            dvs_r     <= '0;
            mag_re    <= '0;
            mag_im    <= '0;
            neg_re    <= 1'b0;
            neg_im    <= 1'b0;
            den_r     <= '0;
            cnt       <= '0;
            q_re      <= '0;
            sat_re    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quot      <= '0;
            sat       <= 1'b0;
            dz        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        dvd_r    <= dvd;
                        dvs_r    <= dvs;
                        in_ready <= 1'b0;
                        state    <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    mag_re <= mag_re_c;
                    mag_im <= mag_im_c;
                    neg_re <= nre_c[NW-1];
                    neg_im <= nim_c[NW-1];
                    den_r  <= den_c;
                    cnt    <= CW'(NW - 1);
                    state  <= ST_DRE;
                end
                ST_DRE: begin
                    if (cnt == '0) begin
                        cnt   <= CW'(NW);
                        state <= ST_DIM;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                // DIM holds one extra cycle so the last imaginary bit lands before capture.
                ST_DIM: begin
                    if (cnt == CW'(NW)) begin
                        q_re   <= re_res[DBW-1:0];
                        sat_re <= re_res[DBW];
                    end
                    if (cnt == '0) begin
                        if (div_done) begin
                            quot      <= dz_c ? '0 : {im_res[DBW-1:0], q_re};
                            sat       <= !dz_c && (sat_re || im_res[DBW]);
                            dz        <= dz_c;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmplxdiv.sv
// tb/tb_cmplxdiv.sv - self-checking bench for cmplxdiv against an integer-arithmetic model
module tb_cmplxdiv;
    localparam int DBW  = 3;
    localparam int MAXV = (2 ** (DBW - 1)) - 1;
    localparam int MINV = -(2 ** (DBW - 1));
    localparam int LAT  = 2 * (3 * DBW + 1) + 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [4*DBW-1:0] dvd = '0;
    logic [2*DBW-1:0] dvs = '0;
    logic             in_ready;
    logic             out_valid;
    logic [2*DBW-1:0] quot;
    logic             sat;
    logic             dz;

    int checks = 0;
    int failures = 0;

    cmplxdiv #(.DBW(DBW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dvd       (dvd),
        .dvs       (dvs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .sat       (sat),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, output bit s);
        s = 1'b0;
        if (v > MAXV) begin s = 1'b1; return MAXV; end
        if (v < MINV) begin s = 1'b1; return MINV; end
        return v;
    endfunction

    // Exact complex quotient via integer division (truncates toward zero), then clamp.
    function automatic void model(input int a, input int b, input int c, input int d,
                                  output logic [2*DBW-1:0] q, output logic s, output logic z);
        int den, qr, qi;
        bit sr, si;
        logic [DBW-1:0] r3, i3;
        den = c * c + d * d;
        if (den == 0) begin
            q = '0; s = 1'b0; z = 1'b1;
            return;
        end
        qr = clamp((a * c + b * d) / den, sr);
        qi = clamp((b * c - a * d) / den, si);
        r3 = qr[DBW-1:0];
        i3 = qi[DBW-1:0];
        q = {i3, r3};
        s = sr | si;
        z = 1'b0;
    endfunction

    task automatic run_op(input int a, input int b, input int c, input int d,
                          input string tag, input bit poke);
        logic [2*DBW-1:0] qe;
        logic se, ze;
        int n, lat;
        model(a, b, c, d, qe, se, ze);
        @(negedge clk);
        dvd = {6'(a), 6'(b)};
        dvs = {3'(d), 3'(c)};
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        chk({tag, "_accept"}, 32'(n < 100), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            if (poke) begin
                in_valid = lat[0];
                dvd = 12'($urandom);
                dvs = 6'($urandom);
            end
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 100);
        in_valid = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(LAT));
        chk({tag, "_quot"}, 32'(quot), 32'(qe));
        chk({tag, "_sat"}, 32'(sat), 32'(se));
        chk({tag, "_dz"}, 32'(dz), 32'(ze));
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_released"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_again"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [2*DBW-1:0] bq;
        logic bs, bz;
        int re1, im1, re2, im2, pre, pim;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quot", 32'(quot), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_dz", 32'(dz), 32'd0);
        rst_n = 1'b1;

        run_op(4, 3, 2, -1, "basic", 1'b0);
        chk("basic_literal", 32'(quot), 32'(6'b010_001));
        release_out("basic");
        run_op(-3, 0, 2, 0, "trunc_neg", 1'b0);
        release_out("trunc_neg");
        run_op(1, 0, 2, 0, "trunc_pos", 1'b0);
        release_out("trunc_pos");
        run_op(20, 0, 1, 0, "sat_pos", 1'b0);
        release_out("sat_pos");
        run_op(-20, 0, 1, 0, "sat_neg", 1'b0);
        release_out("sat_neg");
        run_op(-4, 0, 1, 0, "min_exact", 1'b0);
        release_out("min_exact");
        run_op(5, -7, 0, 0, "div_zero", 1'b0);
        release_out("div_zero");

        // Busy pokes during the operation, then a held DONE with more pokes.
        model(3, -5, 1, 2, bq, bs, bz);
        run_op(3, -5, 1, 2, "busy_poke", 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            dvd = 12'($urandom);
            #1;
            chk("hold_quot", 32'(quot), 32'(bq));
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_out("hold");
        run_op(-2, 1, 1, 1, "after_hold", 1'b0);
        release_out("after_hold");

        // Abort mid-division; quot from the previous op is nonzero.
        @(negedge clk);
        dvd = {6'(12), 6'(-9)};
        dvs = {3'(1), 3'(3)};
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_quot", 32'(quot), 32'd0);
        chk("abort_sat", 32'(sat), 32'd0);
        chk("abort_dz", 32'(dz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(7, 2, -3, 2, "post_abort", 1'b0);
        release_out("post_abort");

        // Product of op1 and op2 fed back must divide to op1.
        for (int k = 0; k < 40; k++) begin
            do begin
                re1 = int'($urandom_range(0, 7)) - 4;
                im1 = int'($urandom_range(0, 7)) - 4;
                re2 = int'($urandom_range(0, 7)) - 4;
                im2 = int'($urandom_range(0, 7)) - 4;
                pre = re1 * re2 - im1 * im2;
                pim = re1 * im2 + im1 * re2;
            end while ((re2 == 0 && im2 == 0) || pre > 31 || pre < -32 || pim > 31 || pim < -32);
            run_op(pre, pim, re2, im2, "rnd", 1'b0);
            chk("rnd_op1", 32'(quot), 32'({3'(im1), 3'(re1)}));
            release_out("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
